// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_pkg
// Purpose  : Shared definitions for the multicycle MIPS-subset core:
//            opcode/funct values, FSM state encoding, ALU control codes,
//            ALUSrcB select encoding and small decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mc_pkg;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_j     = 6'h02;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_bne   = 6'h05;
   localparam logic [5:0] c_op_addi  = 6'h08;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] c_fn_add = 6'h20;
   localparam logic [5:0] c_fn_sub = 6'h22;
   localparam logic [5:0] c_fn_and = 6'h24;
   localparam logic [5:0] c_fn_or  = 6'h25;
   localparam logic [5:0] c_fn_slt = 6'h2A;

   // Controller state encoding
   typedef logic [3:0] state_t;
   localparam state_t c_st_rst    = 4'd0;
   localparam state_t c_st_fetch  = 4'd1;
   localparam state_t c_st_decode = 4'd2;
   localparam state_t c_st_memadr = 4'd3;
   localparam state_t c_st_memrd  = 4'd4;
   localparam state_t c_st_memwb  = 4'd5;
   localparam state_t c_st_memwr  = 4'd6;
   localparam state_t c_st_exec   = 4'd7;
   localparam state_t c_st_aluwb  = 4'd8;
   localparam state_t c_st_addiex = 4'd9;
   localparam state_t c_st_addiwb = 4'd10;
   localparam state_t c_st_branch = 4'd11;
   localparam state_t c_st_jump   = 4'd12;
   localparam state_t c_st_halt   = 4'd13;

   // 3-bit ALU control codes
   localparam logic [2:0] c_alu_and = 3'b000;
   localparam logic [2:0] c_alu_or  = 3'b001;
   localparam logic [2:0] c_alu_add = 3'b010;
   localparam logic [2:0] c_alu_sub = 3'b110;
   localparam logic [2:0] c_alu_slt = 3'b111;

   // ALUSrcB select encoding
   localparam logic [1:0] c_srcb_reg   = 2'b00;  // B register
   localparam logic [1:0] c_srcb_four  = 2'b01;  // constant 4
   localparam logic [1:0] c_srcb_imm   = 2'b10;  // SignImm
   localparam logic [1:0] c_srcb_immsh = 2'b11;  // SignImm << 2

   // True for the R-type function codes the core implements
   function automatic logic funct_legal(input logic [5:0] funct);
      case (funct)
         c_fn_add, c_fn_sub, c_fn_and, c_fn_or, c_fn_slt: return 1'b1;
         default:                                          return 1'b0;
      endcase
   endfunction

   // R-type funct to ALU control; unlisted values fall back to add but
   // never reach EXEC because DECODE routes them to HALT.
   function automatic logic [2:0] funct_to_alu(input logic [5:0] funct);
      case (funct)
         c_fn_sub: return c_alu_sub;
         c_fn_and: return c_alu_and;
         c_fn_or:  return c_alu_or;
         c_fn_slt: return c_alu_slt;
         default:  return c_alu_add;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_regfile.sv
`default_nettype none
// ============================================================================
// Module   : mc_regfile
// Purpose  : NREG x 32 register file, two asynchronous read ports and one
//            synchronous write port. Register 0 is never written, so it
//            holds its reset value of zero and always reads 0.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            ra1, ra2          - read indices (log2(NREG) bits)
//            rd1, rd2          - read data
//            we, wa, wd        - write enable, index, data
// Revision : 1.0 - initial release
// ============================================================================
module mc_regfile #(
   parameter int NREG = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [$clog2(NREG)-1:0]  ra1,
   input  logic [$clog2(NREG)-1:0]  ra2,
   output logic [31:0]              rd1,
   output logic [31:0]              rd2,
   input  logic                     we,
   input  logic [$clog2(NREG)-1:0]  wa,
   input  logic [31:0]              wd
);

   logic [31:0] r_regs [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (we && (wa != '0)) begin
         r_regs[wa] <= wd;
      end
   end

   assign rd1 = r_regs[ra1];
   assign rd2 = r_regs[ra2];

endmodule
`default_nettype wire

// File: rtl/mc_core.sv
`default_nettype none
// ============================================================================
// Module   : mc_core
// Purpose  : Multicycle MIPS-subset core (add/sub/and/or/slt, lw, sw, beq,
//            bne, addi, j) with merged controller and datapath, talking to
//            a unified instruction/data memory through a req/ready handshake.
// Ports    : clk, rst_n                - clock, asynchronous active-low reset
//            mem_req, mem_we           - access request, write qualifier
//            mem_addr, mem_wdata       - word address, store data
//            mem_rdata, mem_ready      - read data, access-complete strobe
//            pc_o                      - current program counter
//            retire                    - pulse in last cycle of instruction
//            halted                    - stopped on an illegal instruction
// Revision : 1.0 - initial release
// ============================================================================
module mc_core
   import mc_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREG     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       pc_o,
   output logic              retire,
   output logic              halted
);

   localparam int c_idx_w = $clog2(NREG);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_aluout;
   logic [31:0] r_mdr;

   // ---------------------------------------------------------------- decode
   logic [5:0]  w_op;
   logic [5:0]  w_funct;
   logic [31:0] w_imm;
   assign w_op    = r_ir[31:26];
   assign w_funct = r_ir[5:0];
   assign w_imm   = {{16{r_ir[15]}}, r_ir[15:0]};

   // ---------------------------------------------------------- register file
   logic [31:0]        w_rd1;
   logic [31:0]        w_rd2;
   logic               w_rf_we;
   logic [c_idx_w-1:0] w_rf_wa;
   logic [31:0]        w_rf_wd;

   // R-type results go to rd; lw and addi results go to rt
   assign w_rf_we = (r_state == c_st_memwb) || (r_state == c_st_aluwb) ||
                    (r_state == c_st_addiwb);
   assign w_rf_wa = (r_state == c_st_aluwb) ? r_ir[11+:c_idx_w] : r_ir[16+:c_idx_w];
   assign w_rf_wd = (r_state == c_st_memwb) ? r_mdr : r_aluout;

   mc_regfile #(
      .NREG (NREG)
   ) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .ra1   (r_ir[21+:c_idx_w]),
      .ra2   (r_ir[16+:c_idx_w]),
      .rd1   (w_rd1),
      .rd2   (w_rd2),
      .we    (w_rf_we),
      .wa    (w_rf_wa),
      .wd    (w_rf_wd)
   );

   // -------------------------------------------------------------------- ALU
   // One shared adder/logic unit: PC+4 in FETCH, branch target in DECODE,
   // effective address / addi sum, and R-type operations in EXEC.
   logic        w_src_a_pc;
   logic [1:0]  w_srcb;
   logic [2:0]  w_alu_ctl;
   logic [31:0] w_alu_a;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_y;

   always_comb begin
      w_src_a_pc = 1'b0;
      w_srcb     = c_srcb_reg;
      w_alu_ctl  = c_alu_add;
      case (r_state)
         c_st_fetch: begin
            w_src_a_pc = 1'b1;
            w_srcb     = c_srcb_four;
         end
         c_st_decode: begin
            w_src_a_pc = 1'b1;
            w_srcb     = c_srcb_immsh;
         end
         c_st_memadr, c_st_addiex: begin
            w_srcb = c_srcb_imm;
         end
         c_st_exec: begin
            w_alu_ctl = funct_to_alu(w_funct);
         end
         default: ;
      endcase
   end

   assign w_alu_a = w_src_a_pc ? r_pc : r_a;

   always_comb begin
      case (w_srcb)
         c_srcb_four:  w_alu_b = 32'd4;
         c_srcb_imm:   w_alu_b = w_imm;
         c_srcb_immsh: w_alu_b = {w_imm[29:0], 2'b00};
         default:      w_alu_b = r_b;
      endcase
   end

   always_comb begin
      case (w_alu_ctl)
         c_alu_and: w_alu_y = w_alu_a & w_alu_b;
         c_alu_or:  w_alu_y = w_alu_a | w_alu_b;
         c_alu_sub: w_alu_y = w_alu_a - w_alu_b;
         c_alu_slt: w_alu_y = {31'd0, ($signed(w_alu_a) < $signed(w_alu_b))};
         default:   w_alu_y = w_alu_a + w_alu_b;
      endcase
   end

   // --------------------------------------------------------- dispatch logic
   state_t w_dispatch;
   always_comb begin
      case (w_op)
         c_op_lw, c_op_sw: w_dispatch = c_st_memadr;
         c_op_rtype:       w_dispatch = funct_legal(w_funct) ? c_st_exec : c_st_halt;
         c_op_addi:        w_dispatch = c_st_addiex;
         c_op_beq,
         c_op_bne:         w_dispatch = c_st_branch;
         c_op_j:           w_dispatch = c_st_jump;
         default:          w_dispatch = c_st_halt;
      endcase
   end

   logic w_take;
   assign w_take = (w_op == c_op_bne) ? (r_a != r_b) : (r_a == r_b);

   // ------------------------------------------------------ state and datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= c_st_rst;
         r_pc     <= RESET_PC;
         r_ir     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_aluout <= '0;
         r_mdr    <= '0;
      end else begin
         case (r_state)
            c_st_rst: r_state <= c_st_fetch;
            c_st_fetch: begin
               if (mem_ready) begin
                  r_ir    <= mem_rdata;
                  r_pc    <= w_alu_y;
                  r_state <= c_st_decode;
               end
            end
            c_st_decode: begin
               r_a      <= w_rd1;
               r_b      <= w_rd2;
               r_aluout <= w_alu_y;
               r_state  <= w_dispatch;
            end
            c_st_memadr: begin
               r_aluout <= w_alu_y;
               r_state  <= (w_op == c_op_sw) ? c_st_memwr : c_st_memrd;
            end
            c_st_memrd: begin
               if (mem_ready) begin
                  r_mdr   <= mem_rdata;
                  r_state <= c_st_memwb;
               end
            end
            c_st_memwr: begin
               if (mem_ready) begin
                  r_state <= c_st_fetch;
               end
            end
            c_st_exec: begin
               r_aluout <= w_alu_y;
               r_state  <= c_st_aluwb;
            end
            c_st_addiex: begin
               r_aluout <= w_alu_y;
               r_state  <= c_st_addiwb;
            end
            c_st_branch: begin
               if (w_take) begin
                  r_pc <= r_aluout;
               end
               r_state <= c_st_fetch;
            end
            c_st_jump: begin
               r_pc    <= {r_pc[31:28], r_ir[25:0], 2'b00};
               r_state <= c_st_fetch;
            end
            c_st_memwb, c_st_aluwb, c_st_addiwb: r_state <= c_st_fetch;
            c_st_halt:  r_state <= c_st_halt;
            // Unreachable encodings stop the core rather than run wild
            default:    r_state <= c_st_halt;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   // Address and store data come straight from registers that do not change
   // while an access is stalled, so they are stable across wait states.
   assign mem_req   = (r_state == c_st_fetch) || (r_state == c_st_memrd) ||
                      (r_state == c_st_memwr);
   assign mem_we    = (r_state == c_st_memwr);
   assign mem_addr  = (r_state == c_st_fetch) ? r_pc[ADDR_W+1:2] : r_aluout[ADDR_W+1:2];
   assign mem_wdata = r_b;
   assign pc_o      = r_pc;
   assign halted    = (r_state == c_st_halt);
   assign retire    = (r_state == c_st_memwb) || (r_state == c_st_aluwb) ||
                      (r_state == c_st_addiwb) || (r_state == c_st_branch) ||
                      (r_state == c_st_jump) || ((r_state == c_st_memwr) && mem_ready);

endmodule
`default_nettype wire

// File: tb/tb_mc_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_core
// Purpose  : Directed self-checking bench for mc_core with a unified
//            256-word memory model and programmable wait states.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [31:0] pc_o;
   logic        retire;
   logic        halted;

   always #5 clk = ~clk;

   mc_core #(
      .ADDR_W   (8),
      .RESET_PC (32'h0000_0000),
      .NREG     (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc_o      (pc_o),
      .retire    (retire),
      .halted    (halted)
   );

   // ------------------------------------------------------------ memory model
   logic [31:0] mem [256];
   int          wcnt = 0;
   int          wait_states = 0;
   logic        ld_en = 1'b0;
   logic        ld_clr = 1'b0;
   logic [7:0]  ld_addr = 8'd0;
   logic [31:0] ld_data = 32'd0;

   assign mem_rdata = mem[mem_addr];
   assign mem_ready = (wcnt >= wait_states);

   always @(posedge clk) begin
      if (ld_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      end else if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end else if (rst_n && mem_req && mem_we && mem_ready) begin
         mem[mem_addr] <= mem_wdata;
      end
      if (!rst_n || !mem_req || mem_ready) wcnt <= 0;
      else                                 wcnt <= wcnt + 1;
   end

   // ---------------------------------------------------------------- monitor
   int          cyc = 0;
   int          retq[$];
   logic [31:0] pcq[$];
   int          wait_cyc = 0;
   int          hold_err = 0;
   bit          prev_ret = 1'b0;
   bit          prev_wait = 1'b0;
   logic [7:0]  p_addr = 8'd0;
   logic        p_we = 1'b0;
   logic [31:0] p_wd = 32'd0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst_n) begin
         if (retire) retq.push_back(cyc);
         if (prev_ret) pcq.push_back(pc_o);
         prev_ret = retire;
         if (mem_req && !mem_ready) begin
            wait_cyc = wait_cyc + 1;
            if (prev_wait && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wd))
               hold_err = hold_err + 1;
         end
         prev_wait = mem_req && !mem_ready;
         p_addr = mem_addr;
         p_we   = mem_we;
         p_wd   = mem_wdata;
      end else begin
         prev_ret  = 1'b0;
         prev_wait = 1'b0;
      end
   end

   // ------------------------------------------------------------- checking
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------ stimulus helpers
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] tgt);
      return {6'h02, tgt};
   endfunction

   localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

   int cyc0, rbase, pbase, wbase, hbase;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int a, input logic [31:0] d);
      ld_addr = a[7:0];
      ld_data = d;
      ld_en   = 1'b1;
      tick();
      ld_en   = 1'b0;
   endtask

   task automatic clear_mem();
      ld_clr = 1'b1;
      tick();
      ld_clr = 1'b0;
   endtask

   // Release reset (called at posedge+1) and check the first fetch
   task automatic release_reset(input string tag);
      cyc0  = cyc;
      rbase = retq.size();
      pbase = pcq.size();
      wbase = wait_cyc;
      hbase = hold_err;
      rst_n = 1'b1;
      @(negedge clk);
      check({tag, "_rst_cycle_req"}, {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      check({tag, "_fetch_req"}, {31'd0, mem_req}, 32'd1);
      check({tag, "_fetch_addr"}, {24'd0, mem_addr}, 32'd0);
      check({tag, "_fetch_pc"}, pc_o, 32'd0);
      check({tag, "_not_halted"}, {31'd0, halted}, 32'd0);
      tick();
   endtask

   task automatic run_to_halt(input string tag);
      int n = 0;
      while (!halted && n < 600) begin
         tick();
         n++;
      end
      check({tag, "_halt_reached"}, {31'd0, halted}, 32'd1);
   endtask

   // Cycle (1 = first FETCH cycle) in which the k-th retire of this run fell
   function automatic int ret_at(input int k);
      if (retq.size() <= rbase + k) return -1000;
      return retq[rbase + k] - cyc0 - 1;
   endfunction

   function automatic logic [31:0] pc_after(input int k);
      if (pcq.size() <= pbase + k) return 32'hDEAD_DEAD;
      return pcq[pbase + k];
   endfunction

   // ------------------------------------------------------------------ main
   initial begin
      int reqs;
      rst_n = 1'b0;

      // ---------------- reset state (memory ready held high)
      wait_states = 0;
      repeat (3) tick();
      @(negedge clk);
      check("reset_req", {31'd0, mem_req}, 32'd0);
      check("reset_we", {31'd0, mem_we}, 32'd0);
      check("reset_retire", {31'd0, retire}, 32'd0);
      check("reset_halted", {31'd0, halted}, 32'd0);
      check("reset_pc", pc_o, 32'd0);
      tick();

      // ---------------- arithmetic, writeback to $0, halt on illegal
      clear_mem();
      put(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd5));        // addi $1,$0,5
      put(1,  enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));     // addi $2,$0,-3
      put(2,  enc_r(5'd1, 5'd2, 5'd3, 6'h20));         // add  $3,$1,$2
      put(3,  enc_r(5'd2, 5'd1, 5'd4, 6'h2A));         // slt  $4,$2,$1
      put(4,  enc_r(5'd2, 5'd1, 5'd6, 6'h22));         // sub  $6,$2,$1
      put(5,  enc_r(5'd1, 5'd2, 5'd7, 6'h25));         // or   $7,$1,$2
      put(6,  enc_r(5'd1, 5'd2, 5'd8, 6'h24));         // and  $8,$1,$2
      put(7,  enc_r(5'd1, 5'd2, 5'd9, 6'h2A));         // slt  $9,$1,$2
      put(8,  enc_i(6'h08, 5'd0, 5'd0, 16'd7));        // addi $0,$0,7
      put(9,  enc_i(6'h2B, 5'd0, 5'd3, 16'd128));      // sw $3,128($0)
      put(10, enc_i(6'h2B, 5'd0, 5'd4, 16'd132));
      put(11, enc_i(6'h2B, 5'd0, 5'd6, 16'd136));
      put(12, enc_i(6'h2B, 5'd0, 5'd7, 16'd140));
      put(13, enc_i(6'h2B, 5'd0, 5'd8, 16'd144));
      put(14, enc_i(6'h2B, 5'd0, 5'd9, 16'd148));
      put(15, enc_i(6'h2B, 5'd0, 5'd0, 16'd152));
      put(16, ILLEGAL);
      put(37, 32'h0000_0011);
      put(38, 32'hDEAD_BEEF);
      release_reset("arith");
      run_to_halt("arith");
      check("arith_retire0", ret_at(0), 32'd4);
      check("arith_retire1", ret_at(1), 32'd8);
      check("arith_retire2", ret_at(2), 32'd12);
      check("arith_retire3", ret_at(3), 32'd16);
      check("arith_retire_count", retq.size() - rbase, 32'd16);
      check("add_result", mem[32], 32'd2);
      check("slt_true", mem[33], 32'd1);
      check("sub_result", mem[34], 32'hFFFF_FFF8);
      check("or_result", mem[35], 32'hFFFF_FFFD);
      check("and_result", mem[36], 32'd5);
      check("slt_false", mem[37], 32'd0);
      check("r0_stays_zero", mem[38], 32'd0);
      reqs = 0;
      repeat (6) begin
         @(negedge clk);
         if (mem_req) reqs++;
      end
      check("halt_no_req", reqs, 32'd0);
      check("halt_pc_frozen", pc_o, 32'h0000_0044);
      check("halt_sticky", {31'd0, halted}, 32'd1);
      tick();

      // ---------------- memory access with two wait states everywhere
      rst_n = 1'b0;
      tick();
      clear_mem();
      put(0, enc_j(26'd4));                            // j to word 4
      put(4, enc_i(6'h08, 5'd0, 5'd1, 16'd5));         // addi $1,$0,5
      put(5, enc_i(6'h2B, 5'd0, 5'd1, 16'd8));         // sw $1,8($0)
      put(6, enc_i(6'h23, 5'd0, 5'd5, 16'd8));         // lw $5,8($0)
      put(7, enc_i(6'h2B, 5'd0, 5'd5, 16'd12));        // sw $5,12($0)
      put(8, ILLEGAL);
      wait_states = 2;
      release_reset("mem");
      run_to_halt("mem");
      check("sw_word2", mem[2], 32'd5);
      check("lw_value", mem[3], 32'd5);
      check("j_cycles_waits", ret_at(0), 32'd5);
      check("sw_cycles_waits", ret_at(2) - ret_at(1), 32'd8);
      check("lw_cycles_waits", ret_at(3) - ret_at(2), 32'd9);
      check("wait_cycle_total", wait_cyc - wbase, 32'd18);
      check("addr_hold_stable", hold_err - hbase, 32'd0);
      tick();

      // ---------------- branches and jump
      rst_n = 1'b0;
      wait_states = 0;
      tick();
      clear_mem();
      put(0,  enc_i(6'h08, 5'd0, 5'd1, 16'd1));        // addi $1,$0,1
      put(1,  enc_i(6'h04, 5'd1, 5'd1, 16'd2));        // beq $1,$1,+2
      put(2,  enc_i(6'h08, 5'd0, 5'd2, 16'd99));
      put(3,  enc_i(6'h08, 5'd0, 5'd2, 16'd98));
      put(4,  enc_i(6'h05, 5'd1, 5'd1, 16'd5));        // bne $1,$1 (falls through)
      put(5,  enc_i(6'h08, 5'd0, 5'd3, 16'd7));        // addi $3,$0,7
      put(6,  enc_i(6'h05, 5'd1, 5'd0, 16'd1));        // bne $1,$0,+1 (taken)
      put(7,  enc_i(6'h08, 5'd0, 5'd3, 16'd55));
      put(8,  enc_i(6'h04, 5'd1, 5'd0, 16'd1));        // beq $1,$0 (falls through)
      put(9,  enc_j(26'h40));                          // j 0x40 -> 0x100
      put(10, ILLEGAL);
      put(32, 32'h0000_AAAA);
      put(64, enc_i(6'h2B, 5'd0, 5'd2, 16'd128));      // sw $2,128($0)
      put(65, enc_i(6'h2B, 5'd0, 5'd3, 16'd132));      // sw $3,132($0)
      put(66, ILLEGAL);
      release_reset("br");
      run_to_halt("br");
      check("pc_after_addi", pc_after(0), 32'd4);
      check("beq_taken_pc", pc_after(1), 32'd16);
      check("bne_equal_pc", pc_after(2), 32'd20);
      check("pc_after_addi2", pc_after(3), 32'd24);
      check("bne_taken_pc", pc_after(4), 32'd32);
      check("beq_unequal_pc", pc_after(5), 32'd36);
      check("jump_pc", pc_after(6), 32'h0000_0100);
      check("pc_after_sw", pc_after(8), 32'h0000_0108);
      check("beq_cycles", ret_at(1) - ret_at(0), 32'd3);
      check("bne_cycles", ret_at(2) - ret_at(1), 32'd3);
      check("j_cycles", ret_at(6) - ret_at(5), 32'd3);
      check("skipped_writes", mem[32], 32'd0);
      check("fallthrough_write", mem[33], 32'd7);
      check("br_halt_pc", pc_o, 32'h0000_010C);
      tick();

      // ---------------- reset during a stalled store
      rst_n = 1'b0;
      tick();
      clear_mem();
      put(0, enc_i(6'h08, 5'd0, 5'd1, 16'd9));         // addi $1,$0,9
      put(1, enc_i(6'h2B, 5'd0, 5'd1, 16'd20));        // sw $1,20($0)
      put(2, ILLEGAL);
      put(5, 32'h1234_5678);
      wait_states = 6;
      release_reset("abort");
      begin
         int n = 0;
         while (!mem_we && n < 200) begin
            tick();
            n++;
         end
      end
      check("abort_store_started", {31'd0, mem_we}, 32'd1);
      tick();
      tick();
      #1 rst_n = 1'b0;
      #1;
      check("abort_req_drop", {31'd0, mem_req}, 32'd0);
      check("abort_we_drop", {31'd0, mem_we}, 32'd0);
      check("abort_pc_reset", pc_o, 32'd0);
      repeat (3) tick();
      check("abort_mem_unchanged", mem[5], 32'h1234_5678);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mc_core.md
# mc_core

Parametrised multicycle MIPS-subset core and the successor to the current fixed multicycle top. It merges the controller FSM and datapath into one block. It talks to a single unified instruction/data memory through a request/ready handshake, so wait states are tolerated. It adds addi, bne and j, a halt state on illegal opcodes, and a retire strobe for the bench and performance counters.

## Interface
- ADDR_W, 8: word-address width of the memory port.
- RESET_PC, 32'h0000_0000: byte address of the first fetch; must be word-aligned.
- NREG, 32: register count, power of two, at most 32. Register index bits above log2(NREG) are ignored.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable, qualifies mem_req.
- mem_addr  out  ADDR_W  word address, equal to byte address bits [ADDR_W+1:2].
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  access completes at the rising edge where mem_req=1 and mem_ready=1.
- pc_o  out  32  current PC.
- retire  out  1  one-cycle pulse in the last cycle of each instruction.
- halted  out  1  core stopped on an illegal opcode.

## Operation
- Instruction set:
  - R-type, op 0x00: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, j 0x02.
  - Any other op, or an unlisted funct under op 0, is illegal.
- FSM states and transitions:
  - RST goes to FETCH.
  - FETCH waits for ready; it then loads IR, sets PC=PC+4, and goes to DECODE.
  - DECODE latches A/B, computes ALUOut=PC+(SignImm<<2), and dispatches.
  - Load/store path: MEMADR (ALUOut=A+SignImm), then MEMRD waiting for ready with MDR=rdata, then MEMWB. Stores go MEMADR, then MEMWR waiting for ready.
  - R-type path: EXEC, then ALUWB.
  - addi path: ADDIEX, then ADDIWB.
  - BRANCH: PC=ALUOut if (A==B) for beq, or (A!=B) for bne.
  - JUMP: PC={PC[31:28], IR[25:0], 2'b00}.
  - Writeback states, MEMWR, BRANCH and JUMP return to FETCH.
  - An illegal opcode goes from DECODE to HALT; HALT is absorbing until reset.
- Register 0 reads 0, and writes to it are dropped.
- Arithmetic is 32-bit two's complement, with overflow ignored (no trap). slt is a signed compare. SignImm is IR[15:0] sign-extended to 32 bits.
- Byte address low bits [1:0] are ignored for lw/sw.
- mem_req=1 only in FETCH, MEMRD and MEMWR; mem_we=1 only in MEMWR.
- While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata are held stable and the FSM does not advance.

## Timing
- Reset values (asynchronous): state=RST, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, all registers 0.
- Output values in reset: mem_req=0, mem_we=0, retire=0, halted=0, pc_o=RESET_PC.
- The first mem_req rises in the first cycle after rst_n deasserts.
- Cycles per instruction with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3. Each wait cycle adds one to FETCH, MEMRD or MEMWR.
- retire is asserted in MEMWB, MEMWR (on its completing cycle), ALUWB, ADDIWB, BRANCH and JUMP.
- A register-file write in a writeback state is visible to reads in the next FETCH/DECODE.
- halted rises the cycle after DECODE of an illegal opcode. PC then stays at the address of the illegal instruction +4 and mem_req stays 0.
- Reset asserted mid-access clears state immediately and drops mem_req. A pending memory transaction is abandoned, and a write is not retried.
- mem_ready=1 while mem_req=0 is ignored.

## Structure
- The shared package mc_pkg holds:
  - opcode and funct localparams;
  - the state enum;
  - the 3-bit ALU control codes (and 010 add, sub 110, and 000, or 001, slt 111);
  - the ALUSrcB select encoding.
- Sub-module mc_regfile: NREG×32, two asynchronous read ports, one synchronous write port, asynchronous reset. The ALU stays inline as a case on the control code.

## Test plan
- Reset: hold rst_n=0 with mem_ready=1. Expect mem_req=0 and pc_o=0. After release, mem_req=1 next cycle with mem_addr=0.
- Arithmetic: `addi $1,$0,5`, then `addi $2,$0,-3`, then `add $3,$1,$2`, then `slt $4,$2,$1`. Expect $3=2, $4=1, and retire pulses at cycles 4, 8, 12 and 16 from the first fetch.
- Memory with waits: `sw $1,8($0)`, then `lw $5,8($0)`, with mem_ready low for 2 cycles on every access. Expect a write to word 2 with data 5, $5=5, lw taking 9 cycles, and the address held stable during waits.
- Branches: beq with equal operands, offset +2, lands at PC+12. bne with equal operands falls through to PC+4. j 0x40 sets pc_o=0x100.
- Illegal opcode 0x3F: halted=1, no further mem_req, and PC frozen. Then a pulse on rst_n restarts fetch at RESET_PC.
- Reset during a MEMWR wait: mem_req and mem_we drop asynchronously, and the memory word is unchanged.
